// File: rtl/fetch_window_queue_if.sv
// Handshake bundle for fetch_window_queue: imem fetch port, pre-decode advance
// inputs and the presented instruction window.
interface fetch_window_queue_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          imem_req;
   logic [31:0]   imem_addr;
   logic          imem_valid;
   logic [127:0]  imem_data;
   logic [31:0]   consume;
   logic          consume_jump;
   logic          hold;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic [31:0]   instr0;
   logic [31:0]   instr1;
   logic [31:0]   instr2;
   logic [31:0]   instr3;
   logic          window_valid;
   logic [31:0]   head_pc;
   logic [CW-1:0] count;

   modport slave (
      output imem_req, imem_addr,
      input  imem_valid, imem_data,
      input  consume, consume_jump, hold, redirect, redirect_pc,
      output instr0, instr1, instr2, instr3, window_valid, head_pc, count
   );

   modport master (
      input  imem_req, imem_addr,
      output imem_valid, imem_data,
      output consume, consume_jump, hold, redirect, redirect_pc,
      input  instr0, instr1, instr2, instr3, window_valid, head_pc, count
   );
endinterface

// File: rtl/fetch_window_queue.sv
// Circular instruction queue feeding a 4-wide pre-decode stage from 128-bit imem lines.
// Optional FWQ_PARTIAL_EN presents partial windows (window_valid when count >= 1).
module fetch_window_queue #(
   parameter int          DEPTH    = 16,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic                 clk,
   input logic                 rst_n,
   fetch_window_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t        state_reg;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] head_ptr_reg;
   logic [AW-1:0] tail_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [31:0]   head_pc_reg;
   logic [31:0]   fetch_pc_reg;
   logic [31:0]   imem_addr_reg;
   logic          imem_req_reg;
   logic [1:0]    skip_reg;

   logic          window_valid_w;
   logic          consume_active;
   logic          do_jump;
   logic          do_flush;
   logic          consume_legal;
   logic          do_pop;
   logic          push_ok;
   logic          issue_idle;
   logic          issue_wait;
   logic          issue;
   logic [2:0]    pop_n;
   logic [2:0]    push_n;
   logic [CW-1:0] count_next;
   logic [31:0]   jump_target;
   logic [31:0]   flush_pc;
   logic [31:0]   line_addr;
   logic [31:0]   instr_w [4];

`ifdef FWQ_PARTIAL_EN
   assign window_valid_w = (count_reg != '0);
`else
   assign window_valid_w = (count_reg >= CW'(4));
`endif

   assign consume_active = !bus.hold && !bus.redirect;
   assign do_jump        = consume_active && bus.consume_jump;
   assign do_flush       = bus.redirect || do_jump;

   // A pop is legal only as whole words, at most one window, never past the valid entries.
   assign consume_legal  = (bus.consume[1:0] == 2'b00) &&
                           (bus.consume <= 32'd16) &&
                           (bus.consume <= (32'(count_reg) << 2)) &&
                           (window_valid_w || (bus.consume == 32'd0));
   assign do_pop         = consume_active && !bus.consume_jump && consume_legal;
   assign pop_n          = do_pop ? bus.consume[4:2] : 3'd0;

   // A response racing a flush belongs to the old stream and is dropped.
   assign push_ok        = (state_reg == WAIT) && bus.imem_valid && !do_flush;
   assign push_n         = push_ok ? (3'd4 - {1'b0, skip_reg}) : 3'd0;
   assign count_next     = count_reg - CW'(pop_n) + CW'(push_n);

   assign issue_idle     = (state_reg == IDLE) && !do_flush && (count_reg <= CW'(DEPTH - 4));
   assign issue_wait     = push_ok && (count_next <= CW'(DEPTH - 4));
   assign issue          = issue_idle || issue_wait;

   assign jump_target    = (head_pc_reg + bus.consume) & ~32'h3;
   assign flush_pc       = bus.redirect ? bus.redirect_pc : jump_target;
   assign line_addr      = fetch_pc_reg & ~32'hF;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         head_ptr_reg  <= '0;
         tail_ptr_reg  <= '0;
         count_reg     <= '0;
         head_pc_reg   <= RESET_PC;
         fetch_pc_reg  <= RESET_PC;
         imem_addr_reg <= '0;
         imem_req_reg  <= 1'b0;
         skip_reg      <= '0;
      end else begin
         imem_req_reg <= issue;
         if (do_flush) begin
            head_ptr_reg <= '0;
            tail_ptr_reg <= '0;
            count_reg    <= '0;
            head_pc_reg  <= flush_pc;
            fetch_pc_reg <= flush_pc;
            // An outstanding request must still be drained unless it completes right now.
            state_reg    <= ((state_reg == IDLE) || bus.imem_valid) ? IDLE : DROP;
         end else begin
            head_ptr_reg <= head_ptr_reg + AW'(pop_n);
            tail_ptr_reg <= tail_ptr_reg + AW'(push_n);
            count_reg    <= count_next;
            if (do_pop) begin
               head_pc_reg <= head_pc_reg + {27'b0, pop_n, 2'b00};
            end
            if (issue) begin
               imem_addr_reg <= line_addr;
               skip_reg      <= fetch_pc_reg[3:2];
               fetch_pc_reg  <= line_addr + 32'd16;
            end
            case (state_reg)
               IDLE: begin
                  if (issue) state_reg <= WAIT;
               end
               WAIT: begin
                  if (bus.imem_valid) state_reg <= issue ? WAIT : IDLE;
               end
               default: begin
                  if (bus.imem_valid) state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   // Words below the start offset of an unaligned target are skipped.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         for (int k = 0; k < 4; k++) begin
            if (k >= int'(skip_reg)) begin
               mem[tail_ptr_reg + AW'(k - int'(skip_reg))] <= bus.imem_data[32*k +: 32];
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [AW-1:0] rd_ptr;
         assign rd_ptr      = head_ptr_reg + AW'(gi);
         assign instr_w[gi] = (count_reg > CW'(gi)) ? mem[rd_ptr] : 32'b0;
      end
   endgenerate

   assign bus.instr0       = instr_w[0];
   assign bus.instr1       = instr_w[1];
   assign bus.instr2       = instr_w[2];
   assign bus.instr3       = instr_w[3];
   assign bus.window_valid = window_valid_w;
   assign bus.head_pc      = head_pc_reg;
   assign bus.count        = count_reg;
   assign bus.imem_req     = imem_req_reg;
   assign bus.imem_addr    = imem_addr_reg;

   consume_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
      (consume_active && !bus.consume_jump) |-> consume_legal);

endmodule

// File: tb/tb_fetch_window_queue.sv
// Directed bench for fetch_window_queue: word-queue model plus imem responder,
// compared every cycle, with literal checks pinning the key scenarios.
module tb_fetch_window_queue;
   localparam int          DEPTH    = 16;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_window_queue_if #(.DEPTH(DEPTH)) bus();

   fetch_window_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // imem responder
   bit          mem_pend = 0;
   logic [31:0] mem_addr = '0;
   int          mem_age  = 0;
   int          mem_lat  = 1;

   // reference model: queue of word addresses plus outstanding-fetch bookkeeping
   logic [31:0] q[$];
   logic [31:0] m_head, m_fetch, m_line;
   logic [1:0]  m_skip;
   bit          m_pend, m_stale, m_req;

   function automatic logic [31:0] word_at(logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   function automatic bit exp_wv(int sz);
`ifdef FWQ_PARTIAL_EN
      return sz >= 1;
`else
      return sz >= 4;
`endif
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
   endtask

   task automatic model_step(logic [31:0] c, bit cj, bit rd, logic [31:0] rpc, bit hd, bit vld);
      bit resp, jmp, idle0, was_stale;
      int sz0;
      logic [31:0] tgt;
      resp      = vld && m_pend;
      jmp       = !rd && !hd && cj;
      idle0     = !m_pend;
      sz0       = q.size();
      was_stale = m_stale;
      m_req     = 0;
      if (rd || jmp) begin
         tgt = rd ? rpc : ((m_head + c) & ~32'h3);
         q.delete();
         m_head  = tgt;
         m_fetch = tgt;
         if (resp) begin
            m_pend  = 0;
            m_stale = 0;
         end else if (m_pend) begin
            m_stale = 1;
         end
      end else begin
         if (!hd && c != 0) begin
            for (int i = 0; i < int'(c / 4); i++) void'(q.pop_front());
            m_head = m_head + c;
         end
         if (resp) begin
            if (!was_stale)
               for (int k = int'(m_skip); k < 4; k++) q.push_back(m_line + 32'(4 * k));
            m_pend  = 0;
            m_stale = 0;
         end
         if ((idle0 && DEPTH - sz0 >= 4) || (resp && !was_stale && DEPTH - q.size() >= 4)) begin
            m_line  = m_fetch & ~32'hF;
            m_skip  = m_fetch[3:2];
            m_fetch = m_line + 32'h10;
            m_pend  = 1;
            m_req   = 1;
         end
      end
   endtask

   task automatic compare_all();
      int sz;
      sz = q.size();
      chk("imem_req", 32'(bus.imem_req), 32'(m_req));
      if (m_req) chk("imem_addr", bus.imem_addr, m_line);
      chk("count", 32'(bus.count), 32'(sz));
      chk("head_pc", bus.head_pc, m_head);
      chk("window_valid", 32'(bus.window_valid), 32'(exp_wv(sz)));
      chk("instr0", bus.instr0, (sz > 0) ? word_at(q[0]) : 32'h0);
      chk("instr1", bus.instr1, (sz > 1) ? word_at(q[1]) : 32'h0);
      chk("instr2", bus.instr2, (sz > 2) ? word_at(q[2]) : 32'h0);
      chk("instr3", bus.instr3, (sz > 3) ? word_at(q[3]) : 32'h0);
   endtask

   task automatic tick(logic [31:0] c, bit cj, bit rd, logic [31:0] rpc, bit hd);
      bus.consume      = c;
      bus.consume_jump = cj;
      bus.redirect     = rd;
      bus.redirect_pc  = rpc;
      bus.hold         = hd;
      bus.imem_valid   = mem_pend && (mem_age >= mem_lat);
      for (int k = 0; k < 4; k++)
         bus.imem_data[32*k +: 32] = bus.imem_valid ? word_at(mem_addr + 32'(4 * k)) : 32'h0;
      model_step(c, cj, rd, rpc, hd, bus.imem_valid);
      @(posedge clk);
      #1;
      cyc++;
      if (bus.imem_valid) begin
         $display("cycle %0d: resp line=%h redirect=%0d jump=%0d", cyc, mem_addr, rd, cj);
         mem_pend = 0;
      end else if (mem_pend) begin
         mem_age++;
      end
      if (bus.imem_req) begin
         mem_pend = 1;
         mem_addr = bus.imem_addr;
         mem_age  = 1;
         $display("cycle %0d: req addr=%h count=%0d head_pc=%h", cyc, bus.imem_addr, bus.count, bus.head_pc);
      end
      compare_all();
   endtask

   task automatic wait_req(int maxc);
      for (int n = 0; n < maxc; n++) begin
         tick(0, 0, 0, 0, 0);
         if (bus.imem_req) return;
      end
      n_checks++;
      $display("FAIL wait_req timeout got=no request want=request within %0d cycles", maxc);
   endtask

   task automatic wait_count(int min_cnt, int maxc);
      for (int n = 0; n < maxc; n++) begin
         tick(0, 0, 0, 0, 0);
         if (int'(bus.count) >= min_cnt) return;
      end
      n_checks++;
      $display("FAIL wait_count timeout got=%0d want>=%0d", bus.count, min_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] tbl [16];
      logic [31:0] c;
      tbl = '{8, 8, 8, 4, 12, 16, 0, 8, 16, 16, 4, 4, 8, 12, 16, 8};

      bus.imem_valid = 0; bus.imem_data = '0; bus.consume = '0; bus.consume_jump = 0;
      bus.hold = 0; bus.redirect = 0; bus.redirect_pc = '0;
      m_head = RESET_PC; m_fetch = RESET_PC; m_line = '0; m_skip = '0;
      m_pend = 0; m_stale = 0; m_req = 0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_head_pc", bus.head_pc, RESET_PC);
      chk("rst_count", 32'(bus.count), 32'h0);
      chk("rst_req", 32'(bus.imem_req), 32'h0);
      chk("rst_addr", bus.imem_addr, 32'h0);
      chk("rst_wvalid", 32'(bus.window_valid), 32'h0);
      chk("rst_instr0", bus.instr0, 32'h0);
      compare_all();
      #2 rst_n = 1;

      // 1: start-up fetches 0x0, 0x10, ...
      tick(0, 0, 0, 0, 0);
      chk("t1_req0", 32'(bus.imem_req), 32'h1);
      chk("t1_addr0", bus.imem_addr, 32'h0);
      tick(0, 0, 0, 0, 0);
      chk("t1_addr1", bus.imem_addr, 32'h10);
      chk("t1_count", 32'(bus.count), 32'h4);
      chk("t1_wvalid", 32'(bus.window_valid), 32'h1);
      chk("t1_instr0", bus.instr0, 32'hC0DE0000);
      repeat (4) tick(0, 0, 0, 0, 0);
      chk("t1_full", 32'(bus.count), 32'd16);

      // 2: mixed consumes with concurrent fills, pointer wrap and drain to empty
      tick(8, 0, 0, 0, 0);
      chk("t2_head8", bus.head_pc, 32'h8);
      chk("t2_instr0", bus.instr0, 32'hC0DE0008);
      for (int i = 0; i < 40; i++) begin
         c = tbl[i % 16];
         if (q.size() < 4 || c > 32'(4 * q.size())) c = 0;
         tick(c, 0, 0, 0, 0);
      end

      // 3: jump 0x24 from head_pc 0x40 -> unaligned start at 0x64
      tick(0, 0, 1, 32'h40, 0);
      wait_count(4, 20);
      chk("t3_head_before", bus.head_pc, 32'h40);
      tick(32'h24, 1, 0, 0, 0);
      chk("t3_head", bus.head_pc, 32'h64);
      chk("t3_flush", 32'(bus.count), 32'h0);
      wait_req(10);
      chk("t3_addr", bus.imem_addr, 32'h60);
      tick(0, 0, 0, 0, 0);
      chk("t3_count", 32'(bus.count), 32'h3);
      chk("t3_instr0", bus.instr0, 32'hC0DE0064);
      chk("t3_instr2", bus.instr2, 32'hC0DE006C);
      chk("t3_instr3", bus.instr3, 32'h0);
      chk("t3_wvalid", 32'(bus.window_valid), 32'(exp_wv(3)));

      // 4: redirect coinciding with a WAIT response
      chk("t4_pre_req", 32'(bus.imem_req), 32'h1);
      tick(0, 0, 1, 32'h200, 0);
      chk("t4_count", 32'(bus.count), 32'h0);
      chk("t4_head", bus.head_pc, 32'h200);
      tick(0, 0, 0, 0, 0);
      chk("t4_req", 32'(bus.imem_req), 32'h1);
      chk("t4_addr", bus.imem_addr, 32'h200);
      tick(0, 0, 0, 0, 0);
      chk("t4_instr0", bus.instr0, 32'hC0DE0200);

      // 5: redirect while DROP, then the late stale response
      mem_lat = 3;
      tick(0, 0, 1, 32'h300, 0);
      chk("t5_head300", bus.head_pc, 32'h300);
      tick(0, 0, 1, 32'h200, 0);
      tick(0, 0, 0, 0, 0);
      chk("t5_dropped", 32'(bus.count), 32'h0);
      wait_req(5);
      chk("t5_addr", bus.imem_addr, 32'h200);
      wait_count(1, 10);
      chk("t5_count", 32'(bus.count), 32'h4);
      chk("t5_instr0", bus.instr0, 32'hC0DE0200);
      chk("t5_instr1", bus.instr1, 32'hC0DE0204);

      // 6: hold for 5 cycles while the queue fills to DEPTH
      mem_lat = 1;
      repeat (5) tick(4, 0, 0, 0, 1);
      chk("t6_count", 32'(bus.count), 32'd16);
      chk("t6_noreq", 32'(bus.imem_req), 32'h0);
      chk("t6_head", bus.head_pc, 32'h200);
      chk("t6_instr0", bus.instr0, 32'hC0DE0200);
      chk("t6_instr3", bus.instr3, 32'hC0DE020C);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
